// File: rtl/rr_grant_encoder.sv
// -----------------------------------------------------------------------------
// rr_grant_encoder
//
// Round-robin arbiter for eight requesters. Produces the registered 3-bit
// index of the current grant holder for the downstream 3-to-8 one-hot
// decoder: gnt_idx drives the decoder select, gnt_valid gates its enables.
// Every grant is followed by one RELEASE cycle and one IDLE cycle with
// gnt_valid low, so the decoded enables never change owner back to back.
//
// Optional feature macro: GRANT_TIMEOUT_EN
//   defined   : a hold counter force-releases a grant after HOLD_MAX cycles
//               and raises timeout_pulse for the first RELEASE cycle.
//   undefined : no counter; a grant ends only on grant_done or request drop,
//               timeout_pulse is constant 0 and HOLD_MAX has no effect.
//
// Parameters
//   N_REQ         number of requesters, must be 8 (3-bit index)
//   HOLD_MAX      max consecutive GRANT cycles (1..255), timeout build only
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req           level-sensitive request vector, bit i = requester i
//   grant_done    one-cycle pulse from the consumer, transfer complete
//   gnt_idx       registered index of the granted requester
//   gnt_valid     registered, gnt_idx is valid and owned
//   timeout_pulse registered one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_grant_encoder #(
    parameter int N_REQ    = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_done,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             timeout_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // The index width and counter width are fixed; reject other sizes at
    // elaboration instead of producing a silently wrong arbiter.
    if ((N_REQ != 8) || (HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_bad_cfg
        $error("rr_grant_encoder: N_REQ must be 8 and HOLD_MAX in 1..255");
    end

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  ptr_r;
    logic [2:0]  ptr_s;
    logic [2:0]  gnt_idx_s;
    logic        gnt_valid_s;
    logic        timeout_pulse_s;

    logic        pick_found_s;
    logic [2:0]  pick_idx_s;
    logic [2:0]  cand_s;
    logic        timeout_hit_s;

`ifdef GRANT_TIMEOUT_EN
    logic [7:0]  hold_cnt_r;
    logic [7:0]  hold_cnt_s;

    // Hold-limit detect: counter equals HOLD_MAX-1 during the last allowed cycle.
    always_comb begin
        timeout_hit_s = (hold_cnt_r == 8'(HOLD_MAX - 1));
    end

    // Hold counter: counts while the grant continues, clears on any other path.
    always_comb begin
        hold_cnt_s = 8'd0;
        if ((state_r == ST_GRANT) && (state_s == ST_GRANT)) begin
            hold_cnt_s = hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_s = 8'd0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else begin
            hold_cnt_r <= hold_cnt_s;
        end
    end
`else
    // Without the timeout feature a grant can never be force-released.
    always_comb begin
        timeout_hit_s = 1'b0;
    end
`endif

    // Rotating priority scan: first set request at ptr, ptr+1, ... ptr+7 (mod 8).
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = 3'd0;
        cand_s       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand_s = ptr_r + 3'(i);
            if (!pick_found_s && req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE / GRANT / RELEASE machine.
    always_comb begin
        state_s         = state_r;
        ptr_s           = ptr_r;
        gnt_idx_s       = gnt_idx;
        gnt_valid_s     = 1'b0;
        timeout_pulse_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_s     = ST_GRANT;
                    gnt_idx_s   = pick_idx_s;
                    gnt_valid_s = 1'b1;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Exit priority: done beats timeout, timeout beats request drop.
                if (grant_done) begin
                    state_s = ST_RELEASE;
                    ptr_s   = gnt_idx + 3'd1;
                end else if (timeout_hit_s) begin
                    state_s         = ST_RELEASE;
                    ptr_s           = gnt_idx + 3'd1;
                    timeout_pulse_s = 1'b1;
                end else if (!req[gnt_idx]) begin
                    state_s = ST_RELEASE;
                    ptr_s   = gnt_idx + 3'd1;
                end else begin
                    state_s     = ST_GRANT;
                    gnt_valid_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ptr_r         <= 3'd0;
            gnt_idx       <= 3'd0;
            gnt_valid     <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            gnt_idx       <= gnt_idx_s;
            gnt_valid     <= gnt_valid_s;
            timeout_pulse <= timeout_pulse_s;
        end
    end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_encoder
//
// Directed bench for rr_grant_encoder. A table of {req, grant_done} inputs
// with hand-computed {gnt_idx, gnt_valid, timeout_pulse} results is applied
// one clock per row; hold-limit and mid-grant reset cases are hand-written
// sequences. HOLD_MAX is set to 4 for the timeout build.
// -----------------------------------------------------------------------------
module tb_rr_grant_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       grant_done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout_pulse;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    rr_grant_encoder #(
        .N_REQ    (8),
        .HOLD_MAX (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .grant_done    (grant_done),
        .gnt_idx       (gnt_idx),
        .gnt_valid     (gnt_valid),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int idx, input int valid, input int to);
        chk({name, ".idx"},   int'(gnt_idx),       idx);
        chk({name, ".valid"}, int'(gnt_valid),     valid);
        chk({name, ".to"},    int'(timeout_pulse), to);
    endtask

    task automatic add(input logic [7:0] r, input logic d, input logic [2:0] i,
                       input logic v, input logic t);
        vec_t e;
        e.req = r; e.done = d; e.idx = i; e.valid = v; e.to = t;
        vecs.push_back(e);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req        = 8'hFF;
        grant_done = 1'b0;

        // Reset held with all requests active: nothing granted.
        tick();
        tick();
        chk_out("reset", 0, 0, 0);

        // Full rotation with done in the first grant cycle: 0..7 then wrap to 0.
        for (int g = 0; g < 9; g++) begin
            add(8'hFF, 1'b0, 3'(g % 8), 1'b1, 1'b0);
            add(8'hFF, 1'b1, 3'(g % 8), 1'b0, 1'b0);
            add(8'hFF, 1'b0, 3'(g % 8), 1'b0, 1'b0);
        end
        // Single requester 2, done during the third grant cycle, then regrant.
        add(8'h04, 1'b0, 3'd2, 1'b1, 1'b0);
        add(8'h04, 1'b0, 3'd2, 1'b1, 1'b0);
        add(8'h04, 1'b0, 3'd2, 1'b1, 1'b0);
        add(8'h04, 1'b1, 3'd2, 1'b0, 1'b0);
        add(8'h04, 1'b0, 3'd2, 1'b0, 1'b0);
        add(8'h04, 1'b0, 3'd2, 1'b1, 1'b0);
        add(8'h04, 1'b1, 3'd2, 1'b0, 1'b0);
        add(8'h00, 1'b0, 3'd2, 1'b0, 1'b0);
        // Grant 5 (ptr -> 6); req 0x03 arriving in RELEASE waits for IDLE, gives 0 then 1.
        add(8'h20, 1'b0, 3'd5, 1'b1, 1'b0);
        add(8'h20, 1'b1, 3'd5, 1'b0, 1'b0);
        add(8'h03, 1'b0, 3'd5, 1'b0, 1'b0);
        add(8'h03, 1'b0, 3'd0, 1'b1, 1'b0);
        add(8'h03, 1'b1, 3'd0, 1'b0, 1'b0);
        add(8'h03, 1'b0, 3'd0, 1'b0, 1'b0);
        add(8'h03, 1'b0, 3'd1, 1'b1, 1'b0);
        add(8'h03, 1'b1, 3'd1, 1'b0, 1'b0);
        add(8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
        // Grant 5 again, then only requester 7.
        add(8'h20, 1'b0, 3'd5, 1'b1, 1'b0);
        add(8'h20, 1'b1, 3'd5, 1'b0, 1'b0);
        add(8'h80, 1'b0, 3'd5, 1'b0, 1'b0);
        add(8'h80, 1'b0, 3'd7, 1'b1, 1'b0);
        add(8'h80, 1'b1, 3'd7, 1'b0, 1'b0);
        add(8'h00, 1'b0, 3'd7, 1'b0, 1'b0);
        // Grant 3 abandoned by its requester: release, no pulse, ptr -> 4.
        add(8'h08, 1'b0, 3'd3, 1'b1, 1'b0);
        add(8'h00, 1'b0, 3'd3, 1'b0, 1'b0);
        add(8'hFF, 1'b0, 3'd3, 1'b0, 1'b0);
        add(8'hFF, 1'b0, 3'd4, 1'b1, 1'b0);
        // Other request bits changing during the grant of 4 have no effect.
        add(8'h1F, 1'b0, 3'd4, 1'b1, 1'b0);
        add(8'h1F, 1'b1, 3'd4, 1'b0, 1'b0);
        add(8'h00, 1'b0, 3'd4, 1'b0, 1'b0);
        // grant_done in IDLE is ignored.
        add(8'h00, 1'b1, 3'd4, 1'b0, 1'b0);
        add(8'h00, 1'b0, 3'd4, 1'b0, 1'b0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            req        = vecs[i].req;
            grant_done = vecs[i].done;
            tick();
            chk_out($sformatf("row%0d", i), int'(vecs[i].idx), int'(vecs[i].valid),
                    int'(vecs[i].to));
        end
        grant_done = 1'b0;

        // Long grant of requester 3 (ptr = 5, so 3 is the first set bit found).
        req = 8'h08;
        tick();
        chk_out("long.c1", 3, 1, 0);
`ifdef GRANT_TIMEOUT_EN
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk_out($sformatf("to.c%0d", k), 3, 1, 0);
        end
        tick();
        chk_out("to.release", 3, 0, 1);
        tick();
        chk_out("to.idle", 3, 0, 0);
        tick();
        chk_out("to.regrant", 3, 1, 0);
        for (int k = 2; k <= 3; k++) begin
            tick();
            chk_out($sformatf("done4.c%0d", k), 3, 1, 0);
        end
        grant_done = 1'b1;
        tick();
        grant_done = 1'b0;
        chk_out("done4.release", 3, 0, 0);
`else
        for (int k = 2; k <= 21; k++) begin
            tick();
            chk_out($sformatf("hold.c%0d", k), 3, 1, 0);
        end
        grant_done = 1'b1;
        tick();
        grant_done = 1'b0;
        chk_out("hold.release", 3, 0, 0);
`endif
        req = 8'h00;
        tick();
        chk_out("pre_rst.idle", 3, 0, 0);
        req = 8'h08;
        tick();
        chk_out("pre_rst.grant", 3, 1, 0);

        // Reset asserted between edges clears outputs without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk_out("post_rst.grant", 3, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
